// File: rtl/shift_sequencer_if.sv
// Command and shift-register datapath bundle for shift_sequencer.
//   master : client side; drives the operation request and the register
//            output sr_out, observes status, result and register controls.
//   slave  : sequencer side; the inverse of master.
// Signals: start/data_in/amount/dir/mode/pause (request), ready/busy/done/
// result (status), sr_in/sr_I/sr_enable/sr_dir (register control), sr_out.
interface shift_sequencer_if #(
    parameter int unsigned N  = 16,
    parameter int unsigned AW = $clog2(N)
);
    logic          start;
    logic [N-1:0]  data_in;
    logic [AW-1:0] amount;
    logic          dir;
    logic [1:0]    mode;
    logic          pause;
    logic          ready;
    logic          busy;
    logic          done;
    logic [N-1:0]  result;
    logic [N-1:0]  sr_in;
    logic          sr_I;
    logic          sr_enable;
    logic          sr_dir;
    logic [N-1:0]  sr_out;

    modport master (
        output start, data_in, amount, dir, mode, pause, sr_out,
        input  ready, busy, done, result, sr_in, sr_I, sr_enable, sr_dir
    );

    modport slave (
        input  start, data_in, amount, dir, mode, pause, sr_out,
        output ready, busy, done, result, sr_in, sr_I, sr_enable, sr_dir
    );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-bit shift/rotate controller for a 1-bit-per-cycle shift register.
// Loads the operand into the external register, then recirculates the
// register output for `amount` enabled cycles while supplying the serial
// fill bit for the selected mode. One operation at a time via start/ready;
// completion is a single-cycle done pulse.
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous, active-low
//   bus    : shift_sequencer_if.slave (request, status, register control)
module shift_sequencer #(
    parameter int unsigned N = 16
) (
    input  logic              clk,
    input  logic              reset,
    shift_sequencer_if.slave  bus
);
    localparam int unsigned AW = $clog2(N);

    localparam logic [1:0] MODE_LOGICAL    = 2'b00;
    localparam logic [1:0] MODE_ARITHMETIC = 2'b01;
    localparam logic [1:0] MODE_ROTATE     = 2'b10;
    localparam logic [1:0] MODE_FILL_ONES  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [N-1:0]  data;
        logic [AW-1:0] amount;
        logic          dir;
        logic [1:0]    mode;
    } op_t;

    state_e        state_q, state_d;
    op_t           op_q, op_d;
    logic [AW-1:0] count_q, count_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          fill_bit;

    // Next-state, operand capture and shift countdown
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d.data   = bus.data_in;
                    op_d.amount = bus.amount;
                    op_d.dir    = bus.dir;
                    op_d.mode   = bus.mode;
                    state_d     = S_LOAD;
                end
            end
            S_LOAD: begin
                count_d = op_q.amount;
                state_d = (op_q.amount != '0) ? S_SHIFT : S_DONE;
            end
            S_SHIFT: begin
                // A paused cycle freezes the count; the last step is taken at count 1
                if (!bus.pause) begin
                    count_d = count_q - AW'(1);
                    if (count_q == AW'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status flags are decoded from the next state so they register cleanly
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    // State and registered status
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            count_q <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            count_q <= count_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Serial fill bit for the selected mode and direction
    always_comb begin
        fill_bit = 1'b0;
        case (op_q.mode)
            MODE_LOGICAL:    fill_bit = 1'b0;
            MODE_ARITHMETIC: fill_bit = op_q.dir ? 1'b0 : bus.sr_out[N-1];
            MODE_ROTATE:     fill_bit = op_q.dir ? bus.sr_out[N-1] : bus.sr_out[0];
            MODE_FILL_ONES:  fill_bit = 1'b1;
            default:         fill_bit = 1'b0;
        endcase
    end

    // Register control: operand only in LOAD, otherwise recirculate sr_out
    assign bus.sr_in     = (state_q == S_LOAD) ? op_q.data : bus.sr_out;
    assign bus.sr_enable = (state_q == S_SHIFT) && !bus.pause;
    assign bus.sr_dir    = op_q.dir;
    assign bus.sr_I      = fill_bit;

    assign bus.ready  = ready_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = bus.sr_out;
endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: models the external shift register, drives
// directed operations and checks every cycle against a timeline model.
module tb_shift_sequencer;
    localparam int unsigned N = 16;

    logic clk = 1'b0;
    logic reset;

    shift_sequencer_if #(.N(N)) bus ();

    shift_sequencer #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // External 1-bit-per-cycle shift register sharing clk/reset
    logic [N-1:0] sr_q;
    always @(posedge clk) begin
        if (!reset)
            sr_q <= '0;
        else if (bus.sr_enable)
            sr_q <= bus.sr_dir ? {bus.sr_in[N-2:0], bus.sr_I} : {bus.sr_I, bus.sr_in[N-1:1]};
        else
            sr_q <= bus.sr_in;
    end
    assign bus.sr_out = sr_q;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Expected result straight from the mode definitions
    function automatic logic [15:0] model(input logic [15:0] d, input int a,
                                          input bit left, input logic [1:0] m);
        logic [15:0] ones;
        ones = 16'hFFFF;
        case (m)
            2'b00:   return left ? (d << a) : (d >> a);
            2'b01:   return left ? (d << a) : 16'($signed(d) >>> a);
            2'b10:   return left ? ((d << a) | (d >> (16 - a))) : ((d >> a) | (d << (16 - a)));
            default: return left ? ((d << a) | ~(ones << a)) : ((d >> a) | ~(ones >> a));
        endcase
    endfunction

    // Current operation timeline
    bit          check_en  = 1'b0;
    bit          op_active = 1'b0;
    int          op_start  = 0;
    int          op_done   = 0;
    logic [15:0] op_exp    = '0;
    logic [15:0] op_data   = '0;
    bit          op_dir    = 1'b0;
    int          done_seen = -1;
    logic [15:0] res_seen  = '0;
    int          en_seen   = 0;
    logic        in_busy;

    // Per-cycle comparison against the timeline
    always @(negedge clk) begin
        if (check_en) begin
            in_busy = op_active && (cyc > op_start) && (cyc <= op_done);
            chk("ready", 32'(bus.ready), 32'(!in_busy));
            chk("busy", 32'(bus.busy), 32'(in_busy));
            chk("done", 32'(bus.done), 32'(op_active && cyc == op_done));
            chk("sr_enable", 32'(bus.sr_enable),
                32'(op_active && cyc > op_start + 1 && cyc < op_done && !bus.pause));
            chk("sr_in", 32'(bus.sr_in),
                32'((op_active && cyc == op_start + 1) ? op_data : bus.sr_out));
            if (in_busy) chk("sr_dir", 32'(bus.sr_dir), 32'(op_dir));
            if (op_active && cyc == op_done) chk("result", 32'(bus.result), 32'(op_exp));
            if (bus.done) begin
                done_seen = cyc;
                res_seen  = bus.result;
            end
            if (bus.sr_enable) en_seen++;
        end
    end

    // One operation; pmask bit k raises pause in relative cycle k, ghost>0 issues
    // an extra start in that relative cycle which must be ignored
    task automatic run_op(input logic [15:0] d, input int a, input bit left,
                          input logic [1:0] m, input logic [31:0] pmask, input int ghost,
                          input int lit_lat, input logic [15:0] lit_res);
        int p, steps, k, s;
        p = 0; steps = 0; k = 2;
        while (steps < a && k < 32) begin
            if (pmask[k]) p++; else steps++;
            k++;
        end
        @(posedge clk); #1;
        s = cyc;
        bus.start   = 1'b1;
        bus.data_in = d;
        bus.amount  = 4'(a);
        bus.dir     = left;
        bus.mode    = m;
        bus.pause   = pmask[0];
        op_start  = s;
        op_done   = s + a + 2 + p;
        op_exp    = model(d, a, left, m);
        op_data   = d;
        op_dir    = left;
        done_seen = -1;
        en_seen   = 0;
        op_active = 1'b1;
        for (int i = 1; i <= a + p + 3; i++) begin
            @(posedge clk); #1;
            bus.start = (i == ghost);
            if (i == ghost) begin
                bus.data_in = ~d;
                bus.amount  = 4'(a + 1);
                bus.dir     = ~left;
                bus.mode    = ~m;
            end
            bus.pause = (i < 32) ? pmask[i] : 1'b0;
        end
        bus.start = 1'b0;
        bus.pause = 1'b0;
        chk("latency", 32'(done_seen - s), 32'(lit_lat));
        chk("result_lit", 32'(res_seen), 32'(lit_res));
        chk("enable_cycles", 32'(en_seen), 32'(a));
    endtask

    // Abort an operation mid-SHIFT with reset
    task automatic reset_mid_shift();
        int s;
        @(posedge clk); #1;
        s = cyc;
        bus.start   = 1'b1;
        bus.data_in = 16'h5555;
        bus.amount  = 4'd8;
        bus.dir     = 1'b1;
        bus.mode    = 2'b00;
        op_start  = s;
        op_done   = s + 10;
        op_exp    = model(16'h5555, 8, 1'b1, 2'b00);
        op_data   = 16'h5555;
        op_dir    = 1'b1;
        done_seen = -1;
        op_active = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            bus.start = (i == 2);
            if (i == 4) reset = 1'b0;
        end
        @(posedge clk); #1;
        reset     = 1'b1;
        op_active = 1'b0;
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        repeat (12) @(posedge clk);
        #1;
        chk("no_done_after_reset", 32'(done_seen), 32'hFFFF_FFFF);
    endtask

    initial begin
        reset       = 1'b0;
        bus.start   = 1'b0;
        bus.data_in = '0;
        bus.amount  = '0;
        bus.dir     = 1'b0;
        bus.mode    = 2'b00;
        bus.pause   = 1'b0;
        @(posedge clk); #1;
        check_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        run_op(16'h8001, 1,  1'b1, 2'b00, 32'h0, 0, 3,  16'h0002);
        run_op(16'h8000, 3,  1'b0, 2'b01, 32'h0, 0, 5,  16'hF000);
        run_op(16'h8000, 3,  1'b1, 2'b01, 32'h0, 0, 5,  16'h0000);
        run_op(16'h4000, 2,  1'b0, 2'b01, 32'h0, 0, 4,  16'h1000);
        run_op(16'h1234, 4,  1'b1, 2'b10, 32'h0, 0, 6,  16'h2341);
        run_op(16'h1234, 4,  1'b0, 2'b10, 32'h0, 0, 6,  16'h4123);
        run_op(16'h1234, 15, 1'b0, 2'b10, 32'h0, 0, 17, 16'h2468);
        run_op(16'h8001, 15, 1'b1, 2'b10, 32'h0, 0, 17, 16'hC000);
        run_op(16'hABCD, 0,  1'b1, 2'b00, 32'h0, 0, 2,  16'hABCD);
        run_op(16'h00F0, 5,  1'b1, 2'b00, 32'h70, 0, 10, 16'h1E00);
        run_op(16'h0F00, 2,  1'b0, 2'b11, 32'h13, 0, 4,  16'hC3C0);
        run_op(16'h00F0, 4,  1'b1, 2'b11, 32'h0, 0, 6,  16'h0F0F);
        run_op(16'h00FF, 3,  1'b0, 2'b00, 32'h0, 1, 5,  16'h001F);
        run_op(16'h1234, 4,  1'b1, 2'b10, 32'h0, 3, 6,  16'h2341);
        run_op(16'h8001, 1,  1'b1, 2'b00, 32'h0, 3, 3,  16'h0002);
        reset_mid_shift();
        run_op(16'h8001, 1,  1'b1, 2'b00, 32'h0, 0, 3,  16'h0002);

        @(posedge clk); #1;
        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
